// File: rtl/counter_pkg.sv
// Shared JK encodings and per-bit excitation helper
// for the synchronous JK counter family.
package counter_pkg;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] RST  = 2'b01;
   localparam logic [1:0] SET  = 2'b10;
   localparam logic [1:0] TOG  = 2'b11;

   // {J,K} that moves a bit from cur to nxt
   function automatic logic [1:0] jk_of(
      input logic cur,
      input logic nxt
   );
      if (cur == nxt)
         return HOLD;
      return TOG;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop, async active-low reset.
// One instance per counter bit.
module jk_cell
   import counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else begin
         unique case ({j, k})
            HOLD: q <= q;
            RST:  q <= 1'b0;
            SET:  q <= 1'b1;
            TOG:  q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_sync_up_counter.sv
// Synchronous modulo-N up counter built from JK cells,
// with clear, load, enable, terminal count and wrap pulse.
module jk_sync_up_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0]      nxt;
   logic [WIDTH-1:0][1:0] jk;
   logic                  at_last;
   logic                  din_ok;

   assign at_last = (count == LAST);
   assign din_ok  = ({1'b0, din} < MOD_EXT);
   assign tc      = at_last & en;

   always_comb begin
      nxt = count;
      if (load)
         nxt = din_ok ? din : '0;
      else if (en)
         nxt = at_last ? '0 : count + WIDTH'(1);
   end

   // Clear, load and wrap force bits explicitly; plain
   // increment falls out of the binary toggle rule.
   always_comb begin
      jk = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (clr)
            jk[i] = RST;
         else if (load)
            jk[i] = nxt[i] ? SET : RST;
         else if (en && at_last)
            jk[i] = count[i] ? RST : HOLD;
         else
            jk[i] = jk_of(count[i], nxt[i]);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (jk[i][1]),
         .k   (jk[i][0]),
         .q   (count[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (clr) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         wrap <= 1'b0;
         if (!din_ok)
            load_err <= 1'b1;
      end else begin
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_jk_sync_up_counter.sv
// Scoreboard bench: mod-16, mod-10 and a two-digit BCD
// cascade checked against an arithmetic reference model.
module tb_jk_sync_up_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  = 1'b0;
   logic       clr  = 1'b0;
   logic       load = 1'b0;
   logic       en   = 1'b0;
   logic       cen  = 1'b0;
   logic [3:0] din  = '0;

   logic [3:0] c16, c10, lo, hi;
   logic t16, w16, e16, t10, w10, e10;
   logic lo_tc, lo_w, lo_e, hi_tc, hi_w, hi_e;

   jk_sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en),
      .din(din), .count(c16), .tc(t16), .wrap(w16),
      .load_err(e16)
   );

   jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en),
      .din(din), .count(c10), .tc(t10), .wrap(w10),
      .load_err(e10)
   );

   jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
      .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .en(cen),
      .din(4'd0), .count(lo), .tc(lo_tc), .wrap(lo_w),
      .load_err(lo_e)
   );

   jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
      .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .en(lo_tc),
      .din(4'd0), .count(hi), .tc(hi_tc), .wrap(hi_w),
      .load_err(hi_e)
   );

   typedef struct {
      int c16; int w16; int e16; int t16;
      int c10; int w10; int e10; int t10;
      int bcd;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   int m16_c = 0, m16_w = 0, m16_e = 0;
   int m10_c = 0, m10_w = 0, m10_e = 0;
   int mcas  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s @%0t: got %0d expected %0d",
                  name, $time, act, exp);
   endtask

   task automatic step_mod(input int m, inout int c,
                           inout int w, inout int e);
      if (!rst) begin
         c = 0; w = 0; e = 0;
      end else if (clr) begin
         c = 0; w = 0; e = 0;
      end else if (load) begin
         w = 0;
         if (int'(din) < m) c = int'(din);
         else begin c = 0; e = 1; end
      end else if (en) begin
         w = (c == m - 1) ? 1 : 0;
         c = (c + 1) % m;
      end else begin
         w = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic cl, input logic ld,
                      input logic e_, input logic [3:0] d,
                      input logic ce);
      exp_t x;
      @(negedge clk);
      rst = r; clr = cl; load = ld; en = e_; din = d; cen = ce;
      step_mod(16, m16_c, m16_w, m16_e);
      step_mod(10, m10_c, m10_w, m10_e);
      if (!r) mcas = 0;
      else if (ce) mcas = (mcas + 1) % 100;
      x.c16 = m16_c; x.w16 = m16_w; x.e16 = m16_e;
      x.t16 = (m16_c == 15 && e_) ? 1 : 0;
      x.c10 = m10_c; x.w10 = m10_w; x.e10 = m10_e;
      x.t10 = (m10_c == 9 && e_) ? 1 : 0;
      x.bcd = (mcas / 10) * 16 + (mcas % 10);
      sb.push_back(x);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk("count16", int'(c16), x.c16);
         chk("wrap16", int'(w16), x.w16);
         chk("err16", int'(e16), x.e16);
         chk("tc16", int'(t16), x.t16);
         chk("count10", int'(c10), x.c10);
         chk("wrap10", int'(w10), x.w10);
         chk("err10", int'(e10), x.e10);
         chk("tc10", int'(t10), x.t10);
         chk("bcd", int'({hi, lo}), x.bcd);
      end
   end

   // Async reset lands between edges; outputs must clear at once
   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      m16_c = 0; m16_w = 0; m16_e = 0;
      m10_c = 0; m10_w = 0; m10_e = 0;
      mcas = 0;
      #1;
      chk("async_c16", int'(c16), m16_c);
      chk("async_c10", int'(c10), m10_c);
      chk("async_w10", int'(w10), m10_w);
      chk("async_e10", int'(e10), m10_e);
      chk("async_bcd", int'({hi, lo}), mcas);
   endtask

   initial begin
      repeat (3) cyc(0, 0, 0, 1, 0, 1);
      repeat (24) cyc(1, 0, 0, 1, 0, 1);

      cyc(1, 0, 1, 0, 4'd5, 1);
      cyc(1, 1, 1, 1, 4'd7, 1);
      cyc(1, 0, 1, 0, 4'd7, 1);
      cyc(1, 0, 0, 1, 4'd0, 1);

      cyc(1, 0, 1, 0, 4'd12, 1);
      repeat (5) cyc(1, 0, 0, 1, 0, 1);
      cyc(1, 1, 0, 0, 0, 1);

      cyc(1, 0, 1, 0, 4'd9, 1);
      repeat (4) cyc(1, 0, 0, 0, 0, 1);
      repeat (2) cyc(1, 0, 0, 1, 0, 1);

      cyc(1, 0, 1, 0, 4'd12, 1);
      cyc(1, 0, 1, 0, 4'd5, 1);
      cyc(1, 0, 0, 1, 0, 1);
      mid_reset();
      cyc(0, 0, 0, 1, 0, 1);
      repeat (130) cyc(1, 0, 0, 1, 0, 1);

      for (int i = 0; i < 400; i++) begin
         cyc(1,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) != 0,
             4'($urandom_range(0, 15)),
             $urandom_range(0, 9) != 0);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jk_sync_up_counter.md
Name: jk_sync_up_counter

Overview:
- Synchronous modulo-N up counter. Every bit is a JK cell clocked by the common clk, so there is no ripple clocking.
- It is the counting-up counterpart of the team's ripple down counter.
- Provides enable, synchronous clear, parallel load and a terminal-count output, so instances cascade into wider counters or act as timebase dividers.
- The J/K inputs for each bit come from shared next-state logic. All bits update on the same edge.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MODULUS, 16, count sequence length. Sequence is 0..MODULUS-1 then wraps to 0. Requires 2 ≤ MODULUS ≤ 2**WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load of din.
- en  input  1  count enable.
- din  input  WIDTH  parallel load value.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: (count == MODULUS-1) & en.
- wrap  output  1  registered one-cycle pulse, high the cycle after count wraps MODULUS-1→0.
- load_err  output  1  registered sticky flag, set by an out-of-range load.

Behaviour:
- Reset (rst=0, asynchronous): count=0, wrap=0, load_err=0. These hold while rst is low. Release is synchronous to the next clk edge; the first count happens on the first rising edge with rst=1 and en=1.
- Priority per edge: clr > load > en > hold.
- clr=1:
  - count←0 (every bit gets J=0, K=1).
  - wrap←0, load_err←0.
- load=1, clr=0:
  - If din < MODULUS: count←din (bit i gets J=din[i], K=~din[i]).
  - If din ≥ MODULUS: count←0 and load_err←1.
  - wrap←0.
- en=1, no clr/load:
  - If count < MODULUS-1: count←count+1. Binary toggle rule: bit i gets J=K=1 iff all lower bits are 1, otherwise J=K=0.
  - If count == MODULUS-1: count←0. Bits at 1 get J=0, K=1. This covers MODULUS that is not a power of two. wrap←1 on this edge.
- en=0, no clr/load:
  - count holds (J=K=0).
  - wrap←0.
- wrap timing: wrap is high for exactly one cycle, after the enabled edge at terminal count. It is never high two consecutive cycles unless MODULUS... (not applicable, since MODULUS ≥ 2).
- tc behaviour:
  - Purely combinational, zero latency.
  - Intended to drive en of the next stage for cascading.
  - Must not depend on clr/load.
- Out-of-range state: count can never exceed MODULUS-1, because load clamps and reset/clear give 0.
- Latency: one clk from clr, load or en to the count change.
- Reset mid-operation: asynchronous clear of all outputs regardless of clr, load or en.

Decomposition:
- Shared package (counter_pkg):
  - JK encoding constants: HOLD=2'b00, RST=2'b01, SET=2'b10, TOG=2'b11.
  - A function that returns JK from (current bit, next bit).
- Sub-module jk_cell: a single JK flip-flop with asynchronous active-low reset, same ports as the existing JK flip-flop. It is instantiated WIDTH times in a generate loop.
- Top level: computes next count, derives per-bit J/K through the package function, and holds the wrap/load_err registers.

Test Plan:
- Reset and count: hold rst=0 for 3 cycles, then release with en=1 and WIDTH=4, MODULUS=16 → count 0 then 1,2,…,15,0. wrap=1 only in the cycle after 15→0. tc=1 only while count=15.
- Non-power-of-two modulus: WIDTH=4, MODULUS=10, en=1 → count 0..9,0. Values 10–15 never appear. wrap pulses once every 10 cycles.
- Priority: with count=5, assert clr=1, load=1, din=7, en=1 on the same edge → count=0. Next edge, load=1 only with din=7 → count=7. Next edge, en=1 → count=8.
- Out-of-range load: MODULUS=10, load din=12 → count=0 and load_err=1, and load_err stays 1 while counting. An edge with clr=1 → load_err=0.
- Enable gating: at count=9 with MODULUS=10, drop en for 4 cycles → count stays 9, tc=0, wrap=0. Raise en → count=0 and wrap pulses once.
- Asynchronous reset mid-count: at count=6, pulse rst low between clock edges → count=0 immediately, before the next edge. wrap=0, load_err=0.
- Cascade check: two instances with the low stage's tc driving the high stage's en, both WIDTH=4, MODULUS=10 → counts 00..99 in BCD and wraps to 00.
